// File: rtl/rob.sv
// Reorder buffer: allocates one entry per issued instruction, collects CDB results,
// retires in program order and flushes on a branch mispredict discovered at commit.
module rob #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             IS_sgn,
  input  logic [4:0]       IS_rd,
  input  logic             IS_is_br,
  input  logic             IS_pred,
  output logic [ROB_W-1:0] IS_ROB_name,
  output logic             IS_full,
  input  logic [ROB_W-1:0] REG_ord1,
  input  logic [ROB_W-1:0] REG_ord2,
  output logic             REG_rdy1,
  output logic             REG_rdy2,
  output logic [31:0]      REG_val1,
  output logic [31:0]      REG_val2,
  input  logic             CDB_sgn,
  input  logic [ROB_W-1:0] CDB_ROB_name,
  input  logic [31:0]      CDB_val,
  input  logic             CDB_jump,
  input  logic [31:0]      CDB_pc,
  output logic             commit_sgn,
  output logic [4:0]       commit_dest,
  output logic [31:0]      commit_value,
  output logic [ROB_W-1:0] commit_ROB_name,
  output logic             clr,
  output logic [31:0]      clr_pc
);

  localparam logic [ROB_W:0] FULL_CNT = (ROB_W+1)'(ROB_SIZE);

  logic [ROB_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [ROB_W:0]      count_q, count_d;
  logic [ROB_SIZE-1:0] busy_q, busy_d, done_q, done_d;

  logic [4:0]          dest_q  [ROB_SIZE];
  logic [31:0]         value_q [ROB_SIZE];
  logic [31:0]         pc_q    [ROB_SIZE];
  logic [ROB_SIZE-1:0] is_br_q, pred_q, jump_q;

  logic             commit_sgn_q, commit_sgn_d;
  logic [4:0]       commit_dest_q, commit_dest_d;
  logic [31:0]      commit_value_q, commit_value_d;
  logic [ROB_W-1:0] commit_tag_q, commit_tag_d;
  logic             clr_q, clr_d;
  logic [31:0]      clr_pc_q, clr_pc_d;

  logic full, alloc, wb, do_commit, mispred;

  // The cycle following a flush ignores every request so all units see a clean slate.
  assign full      = (count_q == FULL_CNT);
  assign alloc     = IS_sgn & ~full & ~clr_q;
  assign wb        = CDB_sgn & ~clr_q & busy_q[CDB_ROB_name];
  assign do_commit = busy_q[head_q] & done_q[head_q] & ~clr_q;
  assign mispred   = do_commit & is_br_q[head_q] & (jump_q[head_q] != pred_q[head_q]);

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    busy_d         = busy_q;
    done_d         = done_q;
    commit_sgn_d   = 1'b0;
    commit_dest_d  = commit_dest_q;
    commit_value_d = commit_value_q;
    commit_tag_d   = commit_tag_q;
    clr_d          = 1'b0;
    clr_pc_d       = clr_pc_q;
    if (wb) done_d[CDB_ROB_name] = 1'b1;
    if (alloc) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      tail_d         = tail_q + ROB_W'(1);
    end
    if (do_commit) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + ROB_W'(1);
      commit_sgn_d   = 1'b1;
      commit_dest_d  = dest_q[head_q];
      commit_value_d = value_q[head_q];
      commit_tag_d   = head_q;
    end
    count_d = count_q + (ROB_W+1)'(alloc) - (ROB_W+1)'(do_commit);
    // The mispredicted branch still retires; everything younger is discarded.
    if (mispred) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      busy_d   = '0;
      clr_d    = 1'b1;
      clr_pc_d = pc_q[head_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      done_q         <= '0;
      commit_sgn_q   <= 1'b0;
      commit_dest_q  <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      clr_q          <= 1'b0;
      clr_pc_q       <= '0;
    end else if (rdy) begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      commit_sgn_q   <= commit_sgn_d;
      commit_dest_q  <= commit_dest_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      clr_q          <= clr_d;
      clr_pc_q       <= clr_pc_d;
    end
  end

  // Entry payload needs no reset: it is only read once busy/done qualify it.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (alloc) begin
        dest_q[tail_q]  <= IS_rd;
        is_br_q[tail_q] <= IS_is_br;
        pred_q[tail_q]  <= IS_pred;
      end
      if (wb) begin
        value_q[CDB_ROB_name] <= CDB_val;
        jump_q[CDB_ROB_name]  <= CDB_jump;
        pc_q[CDB_ROB_name]    <= CDB_pc;
      end
    end
  end

  always_comb begin
    REG_rdy1 = 1'b0;
    REG_val1 = '0;
    if (busy_q[REG_ord1] && done_q[REG_ord1]) begin
      REG_rdy1 = 1'b1;
      REG_val1 = value_q[REG_ord1];
    end else if (CDB_sgn && (CDB_ROB_name == REG_ord1)) begin
      REG_rdy1 = 1'b1;
      REG_val1 = CDB_val;
    end
  end

  always_comb begin
    REG_rdy2 = 1'b0;
    REG_val2 = '0;
    if (busy_q[REG_ord2] && done_q[REG_ord2]) begin
      REG_rdy2 = 1'b1;
      REG_val2 = value_q[REG_ord2];
    end else if (CDB_sgn && (CDB_ROB_name == REG_ord2)) begin
      REG_rdy2 = 1'b1;
      REG_val2 = CDB_val;
    end
  end

  assign IS_ROB_name     = tail_q;
  assign IS_full         = full;
  assign commit_sgn      = commit_sgn_q;
  assign commit_dest     = commit_dest_q;
  assign commit_value    = commit_value_q;
  assign commit_ROB_name = commit_tag_q;
  assign clr             = clr_q;
  assign clr_pc          = clr_pc_q;

endmodule
